fir_mac_seq: RTL and testbench
==============================

Name: fir_mac_seq

Overview:
- Sequential multiply-accumulate engine directly downstream of the 64:1 16-bit tap mux.
- Drives the mux select with a 6-bit tap index, then multiplies each selected sample by a coefficient supplied for the same index.
- Accumulates the 64 signed products and presents one full-precision FIR output per run, with a done pulse.

Parameters:
- DW, 16: sample and coefficient width, signed two's complement.
- TAPS, 64: taps per run; must equal 2**SW.
- SW, 6: select/index width.
- ACCW, 38: accumulator width; must be at least 2*DW+SW, so overflow is impossible.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  request a run; sampled only in IDLE.
- sel  out  SW  tap index to the mux select input and the coefficient ROM address.
- smp  in  DW  selected sample from the mux output; combinational from sel, same cycle.
- coef  in  DW  coefficient for the current sel; combinational, same cycle.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse when acc_out updates.
- acc_out  out  ACCW  signed sum of the 64 products; held until the next completion.

Behaviour:
- Reset (asynchronous, any time including mid-run): state=IDLE, sel=0, cnt=0, prod_r=0, acc=0, acc_out=0, done=0, busy=0. No partial result is produced.
- States: IDLE, RUN, FLUSH.
- IDLE, start=1 at edge E0: acc<=0, cnt<=0, state<=RUN.
- IDLE, start=0: sel held at 0.
- RUN:
  - sel=cnt (registered).
  - Each edge: prod_r <= signed(smp)*signed(coef), 2*DW bits.
  - acc <= acc + sign-extended prod_r, except on the first RUN edge, where prod_r is ignored.
  - cnt increments each edge.
  - When cnt==TAPS-1 at an edge: state<=FLUSH, cnt wraps to 0.
- FLUSH (one cycle):
  - acc_out <= acc + prod_r (tap 63).
  - done <= 1, state <= IDLE.
- done is registered, so it is high for exactly one cycle.
- Timing from E0:
  - sel=k during the cycle after edge E(k).
  - FLUSH follows E64.
  - done and the new acc_out are valid in the cycle after E65.
  - Latency start-edge to done = 65 clocks; busy high for 65 cycles.
- start while busy: ignored, not queued.
- start high in the done cycle: state is already IDLE, so it is accepted. Back-to-back runs have a 66-cycle period.
- Arithmetic:
  - Full signed precision; no rounding, truncation or saturation.
  - -32768*-32768 = 2^30 is legal.
  - The worst-case sum of 2^36 fits ACCW=38.
- The sample buffer must keep smp stable for the whole run; this block does not check it.

Decomposition:
- Package fir_pkg:
  - DW, SW, TAPS, ACCW constants.
  - State typedef (IDLE/RUN/FLUSH).
  - Elaboration check that ACCW >= 2*DW+SW and TAPS == 2**SW.
- One natural sub-module: mac_mul_reg, a registered signed DW x DW multiplier (prod_r stage). It can be retimed or replaced by a DSP primitive without touching the FSM.
- Counter, FSM and accumulator stay in fir_mac_seq.

Test Plan:
- Reset: assert rst mid-run at sel=20 -> busy, done, sel, acc_out go 0 immediately without waiting for clk; after release, a new start completes normally with the correct sum.
- smp=1, coef=1 for every tap -> done exactly 65 clocks after the start edge, acc_out=64, busy high for 65 cycles.
- Model sample buffer returns smp=sel, coef=1 -> acc_out=2016. Then coef=-1 -> acc_out=-2016 (two's complement in 38 bits).
- smp=-32768, coef=-32768 on all taps -> acc_out=68719476736 (2^36), no wrap. smp=-32768, coef=32767 on all taps -> acc_out=-68717379584.
- Pulse start again at sel=10 of an active run -> ignored; single done; acc_out equals the single-run value.
- Hold start=1 continuously -> done every 66 cycles; sel sequence 0..63 then 0 in FLUSH/IDLE; each acc_out correct; acc cleared between runs.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared constants, state encoding and helpers for the sequential 64-tap FIR MAC.
package fir_pkg;

  localparam int DW   = 16;
  localparam int SW   = 6;
  localparam int TAPS = 64;
  localparam int ACCW = 38;

  // Accumulator must hold TAPS full-width products without wrapping.
  localparam bit CFG_OK = (ACCW >= 2*DW + SW) && (TAPS == 2**SW);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  function automatic logic signed [ACCW-1:0] sext_prod(input logic signed [2*DW-1:0] p);
    return {{(ACCW-2*DW){p[2*DW-1]}}, p};
  endfunction

endpackage

// File: rtl/fir_mac_seq_if.sv
// Tap-mux / coefficient / result bundle between the MAC engine and its sample buffer.
interface fir_mac_seq_if;
  import fir_pkg::*;

  logic                   start;
  logic [SW-1:0]          sel;
  logic signed [DW-1:0]   smp;
  logic signed [DW-1:0]   coef;
  logic                   busy;
  logic                   done;
  logic signed [ACCW-1:0] acc_out;

  modport master (input start, smp, coef, output sel, busy, done, acc_out);
  modport slave  (output start, smp, coef, input sel, busy, done, acc_out);
endinterface

// File: rtl/mac_mul_reg.sv
// Registered signed DW x DW multiplier; isolated so it can be retimed or mapped to a DSP.
module mac_mul_reg #(
  parameter int DW = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic signed [DW-1:0]   a,
  input  logic signed [DW-1:0]   b,
  output logic signed [2*DW-1:0] prod_r
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_r <= '0;
    end else if (en) begin
      prod_r <= a * b;
    end
  end

endmodule

// File: rtl/fir_mac_seq.sv
// Sequential FIR engine: walks the tap index, multiplies sample by coefficient and
// accumulates 64 products into one full-precision result with a done pulse.
module fir_mac_seq
  import fir_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  fir_mac_seq_if.master bus
);

  if (!CFG_OK) begin : g_cfg_err
    $error("fir_pkg: ACCW too narrow or TAPS != 2**SW");
  end

  state_t                 state_reg, state_next;
  logic [SW-1:0]          cnt_reg, cnt_next;
  logic signed [ACCW-1:0] acc_reg, acc_next;
  logic signed [ACCW-1:0] acc_out_reg, acc_out_next;
  logic                   done_reg, done_next;
  logic                   mul_en;
  logic signed [2*DW-1:0] prod_r;

  mac_mul_reg #(.DW(DW)) u_mul (
    .clk    (clk),
    .rst    (rst),
    .en     (mul_en),
    .a      (bus.smp),
    .b      (bus.coef),
    .prod_r (prod_r)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      acc_reg     <= '0;
      acc_out_reg <= '0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      acc_reg     <= acc_next;
      acc_out_reg <= acc_out_next;
      done_reg    <= done_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    acc_next     = acc_reg;
    acc_out_next = acc_out_reg;
    done_next    = 1'b0;
    mul_en       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          state_next = RUN;
          cnt_next   = '0;
          acc_next   = '0;
        end
      end
      RUN: begin
        mul_en   = 1'b1;
        cnt_next = cnt_reg + SW'(1);
        // prod_r is one tap behind; on the first RUN edge it holds nothing useful.
        if (cnt_reg != '0) begin
          acc_next = acc_reg + sext_prod(prod_r);
        end
        if (cnt_reg == SW'(TAPS-1)) begin
          state_next = FLUSH;
        end
      end
      FLUSH: begin
        acc_out_next = acc_reg + sext_prod(prod_r);
        done_next    = 1'b1;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.sel     = cnt_reg;
  assign bus.busy    = (state_reg != IDLE);
  assign bus.done    = done_reg;
  assign bus.acc_out = acc_out_reg;

endmodule

// File: tb/tb_fir_mac_seq.sv
// Randomised self-checking bench for fir_mac_seq against a sum-of-products reference.
module tb_fir_mac_seq;
  import fir_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  logic signed [DW-1:0] smp_tab  [TAPS];
  logic signed [DW-1:0] coef_tab [TAPS];

  fir_mac_seq_if bus();

  fir_mac_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sample buffer and coefficient ROM: combinational lookup by tap index.
  always_comb begin
    bus.smp  = smp_tab[bus.sel];
    bus.coef = coef_tab[bus.sel];
  end

  function automatic logic signed [ACCW-1:0] model_sum();
    longint s;
    s = 0;
    for (int i = 0; i < TAPS; i++) s += longint'(smp_tab[i]) * longint'(coef_tab[i]);
    return ACCW'(s);
  endfunction

  task automatic load_random();
    for (int i = 0; i < TAPS; i++) begin
      smp_tab[i]  = DW'($urandom);
      coef_tab[i] = DW'($urandom);
    end
  endtask

  task automatic load_const(input logic signed [DW-1:0] s, input logic signed [DW-1:0] c);
    for (int i = 0; i < TAPS; i++) begin
      smp_tab[i]  = s;
      coef_tab[i] = c;
    end
  endtask

  // Called at a negedge; starts one run and observes 140 cycles after the start edge.
  task automatic do_run(input bit pulse_mid, output int lat, output int busy_n,
                        output int done_n, output int sel_err,
                        output logic signed [ACCW-1:0] res);
    bit pulsed;
    pulsed = 0;
    lat = -1; busy_n = 0; done_n = 0; sel_err = 0; res = '0;
    bus.start = 1'b1;
    for (int n = 1; n <= 140; n++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.busy === 1'b1) busy_n++;
      if (bus.done === 1'b1) begin
        done_n++;
        if (lat < 0) begin
          lat = n - 1;
          res = bus.acc_out;
        end
      end
      if (n <= TAPS && bus.sel !== SW'(n - 1)) sel_err++;
      if ((n == TAPS + 1 || n == TAPS + 2) && bus.sel !== '0) sel_err++;
      if (pulse_mid && !pulsed && bus.sel == SW'(10)) begin
        bus.start = 1'b1;
        pulsed = 1;
      end
    end
    bus.start = 1'b0;
  endtask

  task automatic check_run(input string name, input bit pulse_mid, input logic signed [ACCW-1:0] exp_res);
    int lat, busy_n, done_n, sel_err;
    logic signed [ACCW-1:0] res;
    do_run(pulse_mid, lat, busy_n, done_n, sel_err, res);
    n_checks += 4;
    if (res !== exp_res) begin n_fail++; $display("FAIL %s acc_out: got %0d expected %0d", name, res, exp_res); end
    if (lat !== 65) begin n_fail++; $display("FAIL %s latency: got %0d expected 65", name, lat); end
    if (done_n !== 1) begin n_fail++; $display("FAIL %s done_count: got %0d expected 1", name, done_n); end
    if (busy_n !== 65) begin n_fail++; $display("FAIL %s busy_cycles: got %0d expected 65", name, busy_n); end
    n_checks++;
    if (sel_err !== 0) begin n_fail++; $display("FAIL %s sel_seq: got %0d bad cycles expected 0", name, sel_err); end
    $display("run %s: acc_out=%0d expected=%0d latency=%0d busy=%0d dones=%0d", name, res, exp_res, lat, busy_n, done_n);
  endtask

  task automatic check_zero_outputs(input string name);
    n_checks += 4;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL %s busy: got %b expected 0", name, bus.busy); end
    if (bus.done !== 1'b0) begin n_fail++; $display("FAIL %s done: got %b expected 0", name, bus.done); end
    if (bus.sel !== '0) begin n_fail++; $display("FAIL %s sel: got %0d expected 0", name, bus.sel); end
    if (bus.acc_out !== '0) begin n_fail++; $display("FAIL %s acc_out: got %0d expected 0", name, bus.acc_out); end
  endtask

  task automatic test_reset();
    int waited;
    #1 check_zero_outputs("reset_initial");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    load_random();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    waited = 0;
    while (bus.sel != SW'(20) && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (waited >= 100) begin n_fail++; $display("FAIL reset_wait_sel20: got timeout expected sel=20"); end
    #2 rst = 1'b1;
    #1 check_zero_outputs("reset_midrun");
    $display("reset asserted mid-run at sel=20");
    @(negedge clk);
    rst = 1'b0;
    load_random();
    check_run("after_reset", 1'b0, model_sum());
  endtask

  task automatic test_ones();
    load_const(16'sd1, 16'sd1);
    check_run("ones", 1'b0, model_sum());
  endtask

  task automatic test_ramp();
    for (int i = 0; i < TAPS; i++) begin
      smp_tab[i]  = DW'(i);
      coef_tab[i] = 16'sd1;
    end
    check_run("ramp_pos", 1'b0, model_sum());
    for (int i = 0; i < TAPS; i++) coef_tab[i] = -16'sd1;
    check_run("ramp_neg", 1'b0, model_sum());
  endtask

  task automatic test_extremes();
    load_const(-16'sd32768, -16'sd32768);
    check_run("max_pos", 1'b0, model_sum());
    load_const(-16'sd32768, 16'sd32767);
    check_run("max_neg", 1'b0, model_sum());
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      load_random();
      check_run("random", 1'b0, model_sum());
    end
  endtask

  task automatic test_start_while_busy();
    load_random();
    check_run("start_busy", 1'b1, model_sum());
  endtask

  task automatic test_back_to_back();
    logic signed [ACCW-1:0] exp_q[$];
    logic signed [ACCW-1:0] exp_v;
    int sel_err, done_err, busy_err, pos;
    logic [SW-1:0] exp_sel;
    sel_err = 0; done_err = 0; busy_err = 0;
    load_random();
    exp_q.push_back(model_sum());
    bus.start = 1'b1;
    for (int c = 1; c <= 198; c++) begin
      @(negedge clk);
      pos = (c - 1) % 66;
      exp_sel = (pos < TAPS) ? SW'(pos) : '0;
      if (bus.sel !== exp_sel) sel_err++;
      if (bus.busy !== (pos <= TAPS)) busy_err++;
      if (bus.done !== (pos == 65)) done_err++;
      if (pos == 65) begin
        exp_v = exp_q.pop_front();
        n_checks++;
        if (bus.acc_out !== exp_v) begin n_fail++; $display("FAIL b2b acc_out: got %0d expected %0d", bus.acc_out, exp_v); end
        $display("b2b run done at cycle %0d: acc_out=%0d expected=%0d", c, bus.acc_out, exp_v);
        if (c < 198) begin
          load_random();
          exp_q.push_back(model_sum());
        end else begin
          bus.start = 1'b0;
        end
      end
    end
    n_checks += 3;
    if (sel_err !== 0) begin n_fail++; $display("FAIL b2b sel_seq: got %0d bad cycles expected 0", sel_err); end
    if (busy_err !== 0) begin n_fail++; $display("FAIL b2b busy: got %0d bad cycles expected 0", busy_err); end
    if (done_err !== 0) begin n_fail++; $display("FAIL b2b done_timing: got %0d bad cycles expected 0", done_err); end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    load_const('0, '0);
    test_reset();
    test_ones();
    test_ramp();
    test_extremes();
    test_random();
    test_start_while_busy();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
